// File: rtl/mainbus_arbiter.sv
// MainBus arbiter: round-robin ownership of the shared memory bus among NREQ snooping caches.
// Each tenure runs IDLE -> (SNOOP) -> XFER -> RELEASE; every output is a registered copy of next-state logic.
module mainbus_arbiter #(
  parameter int NREQ      = 4,
  parameter int SNOOPWAIT = 2,
  parameter int MAXHOLD   = 16,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW       = $clog2(MAXHOLD + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   BusReq,
  input  logic [2*NREQ-1:0] BusOp,
  input  logic [NREQ-1:0]   Done,
  input  logic [NREQ-1:0]   SharedIn,
  output logic [NREQ-1:0]   Grant,
  output logic [OW-1:0]     Owner,
  output logic              BusRd,
  output logic              BusUpd,
  output logic              Shared,
  output logic              SnoopDone,
  output logic              Timeout
);

  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_XFER, S_RELEASE} state_t;

  localparam logic [3:0]    SLAST = 4'(SNOOPWAIT - 1);
  localparam logic [CW-1:0] XLAST = CW'(MAXHOLD - 1);

  state_t          state, state_nxt;
  logic [OW-1:0]   ptr, ptr_nxt;
  logic [3:0]      scnt, scnt_nxt;
  logic [CW-1:0]   xcnt, xcnt_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [OW-1:0]   owner_nxt;
  logic            busrd_nxt, busupd_nxt, shared_nxt, snoopdone_nxt, timeout_nxt;

  logic [1:0]      op_arr [NREQ];
  logic            win_vld;
  logic [OW-1:0]   win_idx;
  logic [1:0]      win_op;
  int              cand;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      op_arr[k] = BusOp[2*k +: 2];
    end
  end

  // Search starts one past the last owner so every requester is reached within NREQ tenures.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_vld && BusReq[cand[OW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[OW-1:0];
      end
    end
  end

  assign win_op = op_arr[win_idx];

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    scnt_nxt      = scnt;
    xcnt_nxt      = xcnt;
    grant_nxt     = Grant;
    owner_nxt     = Owner;
    busrd_nxt     = BusRd;
    busupd_nxt    = BusUpd;
    shared_nxt    = Shared;
    snoopdone_nxt = 1'b0;
    timeout_nxt   = Timeout;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          owner_nxt          = win_idx;
          shared_nxt         = 1'b0;
          scnt_nxt           = '0;
          xcnt_nxt           = '0;
          // op[1] set covers WriteBack and the reserved code: no snoop window needed.
          if (win_op[1]) begin
            state_nxt = S_XFER;
          end else begin
            state_nxt  = S_SNOOP;
            busrd_nxt  = ~win_op[0];
            busupd_nxt = win_op[0];
          end
        end
      end
      S_SNOOP: begin
        shared_nxt = Shared | (|(SharedIn & ~Grant));
        if (scnt == SLAST) begin
          state_nxt     = S_XFER;
          busrd_nxt     = 1'b0;
          busupd_nxt    = 1'b0;
          snoopdone_nxt = 1'b1;
        end else begin
          scnt_nxt = scnt + 4'd1;
        end
      end
      S_XFER: begin
        if (Done[Owner] || xcnt == XLAST) begin
          state_nxt  = S_RELEASE;
          grant_nxt  = '0;
          shared_nxt = 1'b0;
          if (!Done[Owner]) timeout_nxt = 1'b1;
        end else begin
          xcnt_nxt = xcnt + 1'b1;
        end
      end
      S_RELEASE: begin
        ptr_nxt   = Owner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= OW'(NREQ - 1);
      scnt      <= '0;
      xcnt      <= '0;
      Grant     <= '0;
      Owner     <= '0;
      BusRd     <= 1'b0;
      BusUpd    <= 1'b0;
      Shared    <= 1'b0;
      SnoopDone <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      scnt      <= scnt_nxt;
      xcnt      <= xcnt_nxt;
      Grant     <= grant_nxt;
      Owner     <= owner_nxt;
      BusRd     <= busrd_nxt;
      BusUpd    <= busupd_nxt;
      Shared    <= shared_nxt;
      SnoopDone <= snoopdone_nxt;
      Timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_mainbus_arbiter.sv
// Directed bench for mainbus_arbiter: inputs driven and outputs sampled on the falling edge.
// Cycle k is the period after rising edge k; inputs set at a falling edge are sampled at the next rising edge.
module tb_mainbus_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] BusReq = '0;
  logic [7:0] BusOp = '0;
  logic [3:0] Done = '0;
  logic [3:0] SharedIn = '0;
  logic [3:0] Grant;
  logic [1:0] Owner;
  logic       BusRd, BusUpd, Shared, SnoopDone, Timeout;
  logic [7:0] obs;

  int n_chk = 0;
  int n_bad = 0;

  assign obs = {Grant, BusRd, BusUpd, SnoopDone, Shared};

  always #5 clock = ~clock;

  mainbus_arbiter dut (
    .clock(clock), .reset(reset), .BusReq(BusReq), .BusOp(BusOp), .Done(Done),
    .SharedIn(SharedIn), .Grant(Grant), .Owner(Owner), .BusRd(BusRd), .BusUpd(BusUpd),
    .Shared(Shared), .SnoopDone(SnoopDone), .Timeout(Timeout)
  );

  task automatic do_reset();
    reset = 1'b1; BusReq = '0; BusOp = '0; Done = '0; SharedIn = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; BusReq = 4'b1111; Done = 4'b1111; SharedIn = 4'b1111;
    repeat (2) @(negedge clock);
    n_chk++;
    if (obs !== 8'h00) begin n_bad++; $display("FAIL reset_obs: got %b want 00000000", obs); end
    n_chk++;
    if ({Owner, Timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_owner_to: got %b want 000", {Owner, Timeout}); end
    reset = 1'b0; BusReq = '0; Done = '0; SharedIn = '0;
    @(negedge clock);
    n_chk++;
    if (obs !== 8'h00) begin n_bad++; $display("FAIL idle_noreq: got %b want 00000000", obs); end
  endtask

  task automatic test_bus_rd();
    logic [7:0] ex [5];
    ex = '{8'b0001_1000, 8'b0001_1000, 8'b0001_0010, 8'b0000_0000, 8'b0000_0000};
    do_reset();
    BusReq = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== ex[k]) begin n_bad++; $display("FAIL busrd_c%0d: got %b want %b", k + 1, obs, ex[k]); end
      BusReq = '0;
      Done = (k == 0 || k == 2) ? 4'b0001 : 4'b0000;
    end
    n_chk++;
    if (Owner !== 2'd0) begin n_bad++; $display("FAIL busrd_owner: got %0d want 0", Owner); end
  endtask

  task automatic test_round_robin();
    int seen, first_sd, gap, multi;
    logic [3:0] exp_g;
    do_reset();
    BusReq = 4'b1111;
    seen = 0; first_sd = -1; gap = -1; multi = 0;
    for (int c = 0; c < 60 && seen < 5; c++) begin
      @(negedge clock);
      if ($countones(Grant) > 1 || (BusRd && BusUpd)) multi++;
      Done = '0;
      if (SnoopDone) begin
        exp_g = 4'(1 << (seen % 4));
        n_chk++;
        if (Grant !== exp_g) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", seen, Grant, exp_g); end
        if (seen == 0) first_sd = c;
        else if (seen == 1) gap = c - first_sd;
        Done = Grant;
        seen++;
      end
    end
    @(negedge clock);
    Done = '0; BusReq = '0;
    n_chk++;
    if (seen !== 5) begin n_bad++; $display("FAIL rr_count: got %0d tenures want 5 (cycle budget expired)", seen); end
    n_chk++;
    if (gap !== 5) begin n_bad++; $display("FAIL rr_gap: got %0d cycles want 5", gap); end
    n_chk++;
    if (multi !== 0) begin n_bad++; $display("FAIL rr_onehot: got %0d bad cycles want 0", multi); end
  endtask

  task automatic test_shared();
    logic [7:0] ex1 [4];
    logic [7:0] ex2 [5];
    ex1 = '{8'b0100_0100, 8'b0100_0100, 8'b0100_0010, 8'b0000_0000};
    ex2 = '{8'b0100_0100, 8'b0100_0100, 8'b0100_0011, 8'b0100_0001, 8'b0000_0000};
    do_reset();
    BusOp = 8'b00_01_00_00; BusReq = 4'b0100; SharedIn = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== ex1[k]) begin n_bad++; $display("FAIL shared_own_c%0d: got %b want %b", k + 1, obs, ex1[k]); end
      BusReq = '0;
      Done = (k == 2) ? 4'b0100 : 4'b0000;
    end
    @(negedge clock);
    BusReq = 4'b0100; SharedIn = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_chk++;
      if (k < 2) begin
        if (obs[7:1] !== ex2[k][7:1]) begin n_bad++; $display("FAIL shared_hit_c%0d: got %b want %b", k + 1, obs[7:1], ex2[k][7:1]); end
      end else if (obs !== ex2[k]) begin
        n_bad++; $display("FAIL shared_hit_c%0d: got %b want %b", k + 1, obs, ex2[k]);
      end
      if (k == 0) begin
        n_chk++;
        if (Owner !== 2'd2) begin n_bad++; $display("FAIL shared_owner: got %0d want 2", Owner); end
      end
      BusReq = '0;
      Done = (k == 3) ? 4'b0100 : 4'b0000;
    end
    SharedIn = '0;
  endtask

  task automatic test_writeback();
    logic [7:0] ex [3];
    ex = '{8'b1000_0000, 8'b1000_0000, 8'b0000_0000};
    do_reset();
    BusOp = 8'b10_00_00_00; BusReq = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_chk++;
      if (obs !== ex[k]) begin n_bad++; $display("FAIL wb_c%0d: got %b want %b", k + 1, obs, ex[k]); end
      BusReq = '0;
      Done = (k == 0) ? 4'b0111 : ((k == 1) ? 4'b1000 : 4'b0000);
    end
    n_chk++;
    if (Owner !== 2'd3) begin n_bad++; $display("FAIL wb_owner: got %0d want 3", Owner); end
    @(negedge clock);
    BusOp = 8'b00_00_11_00; BusReq = 4'b0010;
    @(negedge clock);
    n_chk++;
    if (obs !== 8'b0010_0000) begin n_bad++; $display("FAIL rsv_c1: got %b want 00100000", obs); end
    BusReq = '0; Done = 4'b0010;
    @(negedge clock);
    Done = '0;
    n_chk++;
    if (obs !== 8'b0000_0000) begin n_bad++; $display("FAIL rsv_c2: got %b want 00000000", obs); end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_g;
    logic       exp_to;
    do_reset();
    BusOp = 8'b00_00_10_00; BusReq = 4'b0010;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      exp_g  = (k <= 16) ? 4'b0010 : 4'b0000;
      exp_to = (k == 17);
      n_chk++;
      if ({Grant, Timeout} !== {exp_g, exp_to}) begin
        n_bad++; $display("FAIL timeout_c%0d: got %b want %b", k, {Grant, Timeout}, {exp_g, exp_to});
      end
      BusReq = (k == 17) ? 4'b0011 : 4'b0000;
    end
    BusOp = 8'b00_00_10_00;
    @(negedge clock);
    n_chk++;
    if ({Grant, Timeout} !== 5'b0000_1) begin n_bad++; $display("FAIL timeout_idle: got %b want 00001", {Grant, Timeout}); end
    @(negedge clock);
    n_chk++;
    if ({Grant, Timeout} !== 5'b0001_1) begin n_bad++; $display("FAIL timeout_next: got %b want 00011", {Grant, Timeout}); end
    BusReq = '0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_chk++;
    if ({Grant, Timeout} !== 5'b0000_0) begin n_bad++; $display("FAIL timeout_clr: got %b want 00000", {Grant, Timeout}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    BusReq = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      BusReq = '0;
      Done = (k == 2) ? 4'b0001 : 4'b0000;
    end
    BusReq = 4'b0100;
    @(negedge clock);
    n_chk++;
    if (obs !== 8'b0100_1000) begin n_bad++; $display("FAIL mid_snoop: got %b want 01001000", obs); end
    reset = 1'b1; BusReq = '0;
    @(negedge clock);
    n_chk++;
    if ({obs, Owner} !== 10'b0000_0000_00) begin n_bad++; $display("FAIL mid_abort: got %b want 0000000000", {obs, Owner}); end
    reset = 1'b0; BusReq = 4'b0011;
    @(negedge clock);
    n_chk++;
    if (Grant !== 4'b0001) begin n_bad++; $display("FAIL mid_prio: got %b want 0001", Grant); end
    BusReq = '0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_bus_rd();
    test_round_robin();
    test_shared();
    test_writeback();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mainbus_arbiter.md
MAINBUS_ARBITER -- requirements
Module: mainbus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of caches sharing MainBus.
REQ-002 The block SHALL have parameter SNOOPWAIT, default 2: number of snoop-window cycles, range 1..15.
REQ-003 The block SHALL have parameter MAXHOLD, default 16: maximum number of XFER cycles per tenure before forced release.
REQ-004 The block SHALL have input clock, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have input BusReq, NREQ bits: per-cache bus request, level, held by the requester until granted.
REQ-007 The block SHALL have input BusOp, 2*NREQ bits: per-cache op, 00=BusRd, 01=BusUpd, 10=WriteBack, 11=reserved (treated as WriteBack).
REQ-008 The block SHALL have input Done, NREQ bits: per-cache 1-cycle end-of-transaction pulse.
REQ-009 The block SHALL have input SharedIn, NREQ bits: per-cache snoop hit response.
REQ-010 The block SHALL have output Grant, NREQ bits: one-hot bus ownership, registered.
REQ-011 The block SHALL have output Owner, clog2(NREQ) bits: index of the current or last owner.
REQ-012 The block SHALL have outputs BusRd and BusUpd, 1 bit each: registered broadcasts to the snoopers.
REQ-013 The block SHALL have output Shared, 1 bit: latched OR of the non-owner SharedIn bits.
REQ-014 The block SHALL have output SnoopDone, 1 bit: 1-cycle pulse meaning Shared is final.
REQ-015 The block SHALL have output Timeout, 1 bit: sticky error flag.

Function
REQ-016 The FSM SHALL have states IDLE, SNOOP, XFER and RELEASE; all outputs SHALL be registered.
REQ-017 In IDLE, if any BusReq bit is set, the block SHALL select a winner round-robin, starting from the index after the last winner, load Owner and Grant, and latch the winner's BusOp.
- With no request, the FSM stays in IDLE.
REQ-018 If the latched op is BusRd or BusUpd, IDLE SHALL go to SNOOP; if it is WriteBack or reserved, IDLE SHALL go directly to XFER with Shared=0 and SnoopDone=0.
REQ-019 SNOOP SHALL last exactly SNOOPWAIT cycles.
- BusRd (or BusUpd) = 1 for the whole of SNOOP.
- Shared accumulates the OR of SharedIn bits, excluding the owner's bit.
REQ-020 On the SNOOP-to-XFER transition, the block SHALL drop BusRd/BusUpd and pulse SnoopDone for the first XFER cycle; Shared SHALL hold its value until RELEASE.
REQ-021 In XFER, Done[Owner]=1 SHALL cause a transition to RELEASE.
- Done from non-owners is ignored.
- Done in IDLE or SNOOP is ignored.
REQ-022 In RELEASE (1 cycle), the block SHALL set Grant=0 and Shared=0, update the round-robin pointer to Owner, and go to IDLE.
REQ-023 Latency: request in cycle 0 -> Grant from cycle 1 -> BusRd in cycles 1..SNOOPWAIT -> SnoopDone in cycle SNOOPWAIT+1.
- Done in cycle m -> Grant=0 in cycle m+1.
- Earliest next Grant in cycle m+3.
REQ-024 A request withdrawn before it is granted SHALL be ignored; BusReq changes by the owner during its tenure SHALL have no effect.
REQ-025 An XFER cycle counter SHALL force RELEASE and set Timeout=1 if MAXHOLD XFER cycles elapse without Done[Owner]; the pointer SHALL advance as for a normal release.
REQ-026 Grant SHALL never have more than one bit set, and BusRd and BusUpd SHALL never both be 1.
REQ-027 The block SHALL NOT read or write memory; it only sequences access to it.

Reset
REQ-028 reset=1 at a clock edge SHALL force state IDLE with Grant=0, Owner=0, BusRd=0, BusUpd=0, Shared=0, SnoopDone=0, Timeout=0, and the pointer set so that requester 0 has highest priority.
REQ-029 Reset mid-tenure SHALL abort the tenure with no RELEASE cycle; Timeout is cleared only by reset.

Verification
REQ-030 Reset, then BusReq=0001, BusOp[0]=00 in cycle 0 -> Grant=0001 in cycle 1, BusRd=1 in cycles 1-2, SnoopDone=1 in cycle 3.
REQ-031 BusReq=1111 held, each owner sends Done in its first XFER cycle -> grant order 0,1,2,3,0; Grant is never multi-hot.
REQ-032 Owner 2 with BusUpd and SharedIn=0100 -> Shared=0; with SharedIn=0101 -> Shared=1 at SnoopDone.
REQ-033 WriteBack from requester 3 -> no BusRd/BusUpd, SnoopDone stays 0, XFER from cycle 1.
REQ-034 Owner never sends Done -> forced release after 16 XFER cycles, Timeout=1 held until reset.
REQ-035 Reset asserted in SNOOP -> Grant=0 and BusRd=0 on the next cycle; a following request to requester 0 is granted first.
